lsu_controller: RTL and testbench
=================================

LSU_CONTROLLER -- requirements
Module: lsu_controller

Interface
REQ-001 SHALL provide: clk_i  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL provide: rst_ni  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide: core_req_i  in  1  core memory request (load/store from decoder mem_req).
REQ-004 SHALL provide: core_we_i  in  1  1=store, 0=load.
REQ-005 SHALL provide: core_size_i  in  3  LDST_B=0, LDST_H=1, LDST_W=2, LDST_BU=4, LDST_HU=5.
REQ-006 SHALL provide: core_addr_i  in  32  byte address; core_wd_i  in  32  store data (rs2).
REQ-007 SHALL provide: core_rd_o  out  32  extended load data; core_stall_o  out  1  hold core pipeline.
REQ-008 SHALL provide: lsu_err_o  out  1  misaligned address or illegal size; single-cycle.
REQ-009 SHALL provide: mem_req_o, mem_we_o  out  1 each; mem_be_o  out  4; mem_addr_o, mem_wd_o  out  32.
REQ-010 SHALL provide: mem_rd_i  in  32  read word; mem_ready_i  in  1  access complete this cycle.

Function
REQ-011 SHALL implement a two-state FSM: IDLE, WAIT.
REQ-012 IDLE->WAIT when core_req_i=1 and lsu_err_o=0.
REQ-013 WAIT->IDLE when mem_ready_i=1; otherwise remain in WAIT.
REQ-014 On the IDLE->WAIT transition, SHALL latch core_size_i and core_addr_i[1:0] for load extraction.
REQ-015 lsu_err_o=1 combinationally when core_req_i=1 in IDLE and: size H/HU with addr[0]=1; size W with addr[1:0]!=0; or size in {3,6,7}.
REQ-016 With lsu_err_o=1: mem_req_o=0, core_stall_o=0, FSM stays IDLE.
REQ-017 mem_req_o SHALL be 1 when core_req_i=1 and lsu_err_o=0 in IDLE, and throughout WAIT until and including the mem_ready_i cycle.
REQ-018 mem_we_o=core_we_i and mem_addr_o={core_addr_i[31:2],2'b00} whenever mem_req_o=1; core inputs are stable while core_stall_o=1.
REQ-019 core_stall_o = core_req_i AND NOT(state==WAIT AND mem_ready_i) AND NOT lsu_err_o; minimum access latency 2 cycles (issue + ready).
REQ-020 Store B: mem_be_o=4'b0001<<addr[1:0], mem_wd_o={4{wd[7:0]}}.
REQ-021 Store H: mem_be_o=addr[1]?4'b1100:4'b0011, mem_wd_o={2{wd[15:0]}}.
REQ-022 Store W: mem_be_o=4'b1111, mem_wd_o=wd.
REQ-023 Loads SHALL drive mem_be_o=4'b1111.
REQ-024 core_rd_o from mem_rd_i using latched size/offset:
- B/BU: byte [8*off+7:8*off], sign/zero-extended.
- H/HU: half [16*off[1]+15:16*off[1]], sign/zero-extended.
- W: word unchanged.
REQ-025 core_rd_o SHALL be valid in the cycle core_stall_o deasserts with state==WAIT; undefined-but-stable otherwise.
REQ-026 mem_ready_i in IDLE SHALL be ignored.
REQ-027 core_req_i dropping in WAIT (illegal protocol) SHALL still complete on mem_ready_i, with core_stall_o=0.
REQ-028 Back-to-back: a new request in the cycle after WAIT->IDLE SHALL issue with no bubble.

Reset
REQ-029 rst_ni=0 SHALL asynchronously force state=IDLE and clear latched size/offset to 0.
REQ-030 While rst_ni=0: mem_req_o=0, mem_we_o=0, core_stall_o=0, lsu_err_o=0, mem_be_o=0.
REQ-031 Reset asserted during WAIT SHALL abandon the access; first cycle after release is IDLE.

Verification
REQ-032 LW addr 0x100, mem_ready_i on 2nd cycle, mem_rd_i=0xDEADBEEF -> stall 1 cycle, mem_addr_o=0x100, core_rd_o=0xDEADBEEF.
REQ-033 LB addr 0x103, mem_rd_i=0x80112233 -> core_rd_o=0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x00008011.
REQ-034 SH addr 0x22, wd=0x0000ABCD -> mem_be_o=4'b1100, mem_wd_o=0xABCDABCD, mem_we_o=1; SB addr 0x21 -> be=4'b0010.
REQ-035 LW addr 0x101 or core_size_i=3 -> lsu_err_o=1, mem_req_o=0, core_stall_o=0, state IDLE.
REQ-036 Store issued, mem_ready_i held 0 for 5 cycles -> core_stall_o=1 and outputs stable 6 cycles; then ready -> stall drops.
REQ-037 rst_ni pulsed low mid-WAIT -> mem_req_o=0 immediately; new LW after release issues normally.

Source files
------------

// File: rtl/lsu_controller_if.sv
// Memory-side bus of the load/store unit.
// master: LSU drives request/strobe/addr/data; slave: memory returns rd/ready.
interface lsu_controller_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  modport master (
    output mem_req_o,
    output mem_we_o,
    output mem_be_o,
    output mem_addr_o,
    output mem_wd_o,
    input  mem_rd_i,
    input  mem_ready_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_we_o,
    input  mem_be_o,
    input  mem_addr_o,
    input  mem_wd_o,
    output mem_rd_i,
    output mem_ready_i
  );
endinterface

// File: rtl/lsu_controller.sv
// Two-state load/store controller: alignment check, byte lanes, load extend.
// Ports: clk_i/rst_ni, core_* request side, mem (lsu_controller_if.master).
module lsu_controller (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             core_req_i,
  input  logic             core_we_i,
  input  logic [2:0]       core_size_i,
  input  logic [31:0]      core_addr_i,
  input  logic [31:0]      core_wd_i,
  output logic [31:0]      core_rd_o,
  output logic             core_stall_o,
  output logic             lsu_err_o,
  lsu_controller_if.master mem
);
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t     state_q;
  logic [2:0] size_q;
  logic [1:0] off_q;

  logic busy;
  logic bad;
  logic issue;
  logic is_b;
  logic is_h;

  assign busy = (state_q == S_WAIT);
  assign is_b = (core_size_i[1:0] == 2'd0);
  assign is_h = (core_size_i[1:0] == 2'd1);

  always_comb begin
    bad = 1'b0;
    if (core_size_i == 3'd3 || core_size_i[2:1] == 2'b11)
      bad = 1'b1;
    if ((core_size_i == LDST_H || core_size_i == LDST_HU)
        && core_addr_i[0])
      bad = 1'b1;
    if (core_size_i == LDST_W && core_addr_i[1:0] != 2'b00)
      bad = 1'b1;
  end

  // rst_ni gates the combinational outputs so nothing leaks while in reset
  assign lsu_err_o = rst_ni & ~busy & core_req_i & bad;
  assign issue     = rst_ni & ~busy & core_req_i & ~bad;

  assign mem.mem_req_o  = issue | (rst_ni & busy);
  assign mem.mem_we_o   = mem.mem_req_o & core_we_i;
  assign mem.mem_addr_o = {core_addr_i[31:2], 2'b00};

  assign core_stall_o = rst_ni & core_req_i
                      & ~(busy & mem.mem_ready_i)
                      & ~lsu_err_o;

  always_comb begin
    mem.mem_be_o = 4'b0000;
    if (rst_ni) begin
      mem.mem_be_o = 4'b1111;
      if (core_we_i) begin
        unique case (1'b1)
          is_b:    mem.mem_be_o = 4'b0001 << core_addr_i[1:0];
          is_h:    mem.mem_be_o = core_addr_i[1] ? 4'b1100
                                                 : 4'b0011;
          default: mem.mem_be_o = 4'b1111;
        endcase
      end
    end
  end

  always_comb begin
    unique case (1'b1)
      is_b:    mem.mem_wd_o = {4{core_wd_i[7:0]}};
      is_h:    mem.mem_wd_o = {2{core_wd_i[15:0]}};
      default: mem.mem_wd_o = core_wd_i;
    endcase
  end

  logic [7:0]  rd_b;
  logic [15:0] rd_h;
  logic        sx;

  assign rd_h = off_q[1] ? mem.mem_rd_i[31:16] : mem.mem_rd_i[15:0];
  assign sx   = ~size_q[2];

  always_comb begin
    unique case (off_q)
      2'd0:    rd_b = mem.mem_rd_i[7:0];
      2'd1:    rd_b = mem.mem_rd_i[15:8];
      2'd2:    rd_b = mem.mem_rd_i[23:16];
      default: rd_b = mem.mem_rd_i[31:24];
    endcase
  end

  always_comb begin
    unique case (size_q[1:0])
      2'd0:    core_rd_o = {{24{sx & rd_b[7]}}, rd_b};
      2'd1:    core_rd_o = {{16{sx & rd_h[15]}}, rd_h};
      default: core_rd_o = mem.mem_rd_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      size_q  <= 3'd0;
      off_q   <= 2'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (issue) begin
            state_q <= S_WAIT;
            size_q  <= core_size_i;
            off_q   <= core_addr_i[1:0];
          end
        end
        default: begin
          if (mem.mem_ready_i)
            state_q <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_controller.sv
// Self-checking bench for lsu_controller: vector table plus
// hand sequences for reset, back-to-back and protocol corner cases.
module tb_lsu_controller;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        core_req_i = 1'b0;
  logic        core_we_i = 1'b0;
  logic [2:0]  core_size_i = 3'd0;
  logic [31:0] core_addr_i = '0;
  logic [31:0] core_wd_i = '0;
  logic [31:0] core_rd_o;
  logic        core_stall_o;
  logic        lsu_err_o;

  lsu_controller_if mem ();

  lsu_controller dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .core_req_i   (core_req_i),
    .core_we_i    (core_we_i),
    .core_size_i  (core_size_i),
    .core_addr_i  (core_addr_i),
    .core_wd_i    (core_wd_i),
    .core_rd_o    (core_rd_o),
    .core_stall_o (core_stall_o),
    .lsu_err_o    (lsu_err_o),
    .mem          (mem.master)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          nwait;
    logic        err;
    logic [3:0]  be;
    logic [31:0] mwd;
    logic [31:0] rd;
  } vec_t;

  vec_t        vecs[18];
  logic [31:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic pop_chk(input string name);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s got empty-queue want entry", name);
    end else begin
      e = exp_q.pop_front();
      chk(name, core_rd_o, e);
    end
  endtask

  task automatic drive(input logic we, input logic [2:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    core_req_i  = 1'b1;
    core_we_i   = we;
    core_size_i = sz;
    core_addr_i = a;
    core_wd_i   = wd;
  endtask

  initial begin
    vecs[0]  = '{0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0, 0, 4'hF, 0, 32'hDEADBEEF};
    vecs[1]  = '{0, 3'd0, 32'h103, 0, 32'h80112233, 0, 0, 4'hF, 0, 32'hFFFFFF80};
    vecs[2]  = '{0, 3'd4, 32'h103, 0, 32'h80112233, 1, 0, 4'hF, 0, 32'h00000080};
    vecs[3]  = '{0, 3'd5, 32'h102, 0, 32'h80112233, 0, 0, 4'hF, 0, 32'h00008011};
    vecs[4]  = '{0, 3'd1, 32'h102, 0, 32'h80112233, 0, 0, 4'hF, 0, 32'hFFFF8011};
    vecs[5]  = '{0, 3'd0, 32'h100, 0, 32'h80112233, 0, 0, 4'hF, 0, 32'h00000033};
    vecs[6]  = '{0, 3'd1, 32'h100, 0, 32'h80112233, 2, 0, 4'hF, 0, 32'h00002233};
    vecs[7]  = '{0, 3'd0, 32'h102, 0, 32'h00AB0000, 0, 0, 4'hF, 0, 32'hFFFFFFAB};
    vecs[8]  = '{0, 3'd4, 32'h101, 0, 32'h0000FF00, 0, 0, 4'hF, 0, 32'h000000FF};
    vecs[9]  = '{1, 3'd1, 32'h22, 32'h0000ABCD, 0, 0, 0, 4'hC, 32'hABCDABCD, 0};
    vecs[10] = '{1, 3'd0, 32'h21, 32'h12345678, 0, 0, 0, 4'h2, 32'h78787878, 0};
    vecs[11] = '{1, 3'd2, 32'h40, 32'hCAFEF00D, 0, 5, 0, 4'hF, 32'hCAFEF00D, 0};
    vecs[12] = '{1, 3'd1, 32'h20, 32'h1234BEEF, 0, 2, 0, 4'h3, 32'hBEEFBEEF, 0};
    vecs[13] = '{0, 3'd2, 32'h101, 0, 0, 0, 1, 4'h0, 0, 0};
    vecs[14] = '{0, 3'd3, 32'h100, 0, 0, 0, 1, 4'h0, 0, 0};
    vecs[15] = '{0, 3'd1, 32'h103, 0, 0, 0, 1, 4'h0, 0, 0};
    vecs[16] = '{0, 3'd5, 32'h101, 0, 0, 0, 1, 4'h0, 0, 0};
    vecs[17] = '{1, 3'd7, 32'h200, 0, 0, 0, 1, 4'h0, 0, 0};

    mem.mem_rd_i    = '0;
    mem.mem_ready_i = 1'b0;

    drive(1'b1, 3'd2, 32'h100, 32'h1);
    #12;
    chk("rst_req", {31'd0, mem.mem_req_o}, 32'd0);
    chk("rst_we", {31'd0, mem.mem_we_o}, 32'd0);
    chk("rst_stall", {31'd0, core_stall_o}, 32'd0);
    chk("rst_err", {31'd0, lsu_err_o}, 32'd0);
    chk("rst_be", {28'd0, mem.mem_be_o}, 32'd0);
    core_req_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 18; i++) begin
      cyc();
      drive(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wd);
      mem.mem_ready_i = 1'b0;
      @(negedge clk_i);
      chk($sformatf("v%0d_err", i), {31'd0, lsu_err_o}, {31'd0, vecs[i].err});
      chk($sformatf("v%0d_req", i), {31'd0, mem.mem_req_o}, {31'd0, ~vecs[i].err});
      chk($sformatf("v%0d_stall", i), {31'd0, core_stall_o}, {31'd0, ~vecs[i].err});
      if (!vecs[i].err) begin
        if (!vecs[i].we) exp_q.push_back(vecs[i].rd);
        for (int k = 0; k <= vecs[i].nwait; k++) begin
          if (k > 0) begin
            cyc();
            @(negedge clk_i);
            chk($sformatf("v%0d_wstall", i), {31'd0, core_stall_o}, 32'd1);
          end
          chk($sformatf("v%0d_addr", i), mem.mem_addr_o,
              {vecs[i].addr[31:2], 2'b00});
          chk($sformatf("v%0d_be", i), {28'd0, mem.mem_be_o}, {28'd0, vecs[i].be});
          chk($sformatf("v%0d_we", i), {31'd0, mem.mem_we_o}, {31'd0, vecs[i].we});
          if (vecs[i].we)
            chk($sformatf("v%0d_wd", i), mem.mem_wd_o, vecs[i].mwd);
        end
        cyc();
        mem.mem_ready_i = 1'b1;
        mem.mem_rd_i    = vecs[i].rdata;
        @(negedge clk_i);
        chk($sformatf("v%0d_done", i), {31'd0, core_stall_o}, 32'd0);
        chk($sformatf("v%0d_dreq", i), {31'd0, mem.mem_req_o}, 32'd1);
        if (!vecs[i].we) pop_chk($sformatf("v%0d_rd", i));
      end
      cyc();
      core_req_i      = 1'b0;
      mem.mem_ready_i = 1'b0;
      @(negedge clk_i);
      chk($sformatf("v%0d_idle", i), {31'd0, mem.mem_req_o}, 32'd0);
    end

    // back-to-back loads with no idle cycle in between
    cyc();
    drive(1'b0, 3'd2, 32'h300, 0);
    exp_q.push_back(32'h01020304);
    cyc();
    mem.mem_ready_i = 1'b1;
    mem.mem_rd_i    = 32'h01020304;
    @(negedge clk_i);
    pop_chk("b2b_rd0");
    cyc();
    drive(1'b0, 3'd4, 32'h306, 0);
    mem.mem_ready_i = 1'b0;
    exp_q.push_back(32'h000000C3);
    @(negedge clk_i);
    chk("b2b_req", {31'd0, mem.mem_req_o}, 32'd1);
    chk("b2b_stall", {31'd0, core_stall_o}, 32'd1);
    chk("b2b_addr", mem.mem_addr_o, 32'h304);
    cyc();
    mem.mem_ready_i = 1'b1;
    mem.mem_rd_i    = 32'h55C30000;
    @(negedge clk_i);
    pop_chk("b2b_rd1");
    cyc();
    core_req_i      = 1'b0;

    // ready in IDLE ignored; request dropped in WAIT still completes
    @(negedge clk_i);
    chk("ri_req", {31'd0, mem.mem_req_o}, 32'd0);
    cyc();
    drive(1'b0, 3'd2, 32'h400, 0);
    @(negedge clk_i);
    chk("ri_stall", {31'd0, core_stall_o}, 32'd1);
    cyc();
    core_req_i      = 1'b0;
    mem.mem_ready_i = 1'b0;
    @(negedge clk_i);
    chk("drop_stall", {31'd0, core_stall_o}, 32'd0);
    chk("drop_req", {31'd0, mem.mem_req_o}, 32'd1);
    cyc();
    mem.mem_ready_i = 1'b1;
    @(negedge clk_i);
    chk("drop_rdy_req", {31'd0, mem.mem_req_o}, 32'd1);
    cyc();
    mem.mem_ready_i = 1'b0;
    @(negedge clk_i);
    chk("drop_idle", {31'd0, mem.mem_req_o}, 32'd0);

    // reset mid-WAIT abandons the store
    cyc();
    drive(1'b1, 3'd2, 32'h500, 32'h77);
    cyc();
    rst_ni = 1'b0;
    #1;
    chk("mrst_req", {31'd0, mem.mem_req_o}, 32'd0);
    chk("mrst_stall", {31'd0, core_stall_o}, 32'd0);
    drive(1'b0, 3'd2, 32'h200, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("post_req", {31'd0, mem.mem_req_o}, 32'd1);
    chk("post_stall", {31'd0, core_stall_o}, 32'd1);
    chk("post_we", {31'd0, mem.mem_we_o}, 32'd0);
    exp_q.push_back(32'h11223344);
    cyc();
    mem.mem_ready_i = 1'b1;
    mem.mem_rd_i    = 32'h11223344;
    @(negedge clk_i);
    chk("post_done", {31'd0, core_stall_o}, 32'd0);
    pop_chk("post_rd");
    cyc();
    core_req_i      = 1'b0;
    mem.mem_ready_i = 1'b0;
    @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
